// File: rtl/uart_word_io_pkg.sv
// uart_word_io_pkg: shared FSM state type and byte/word geometry.
package uart_word_io_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_e;
endpackage

// File: rtl/uart_word_io_if.sv
// uart_word_io_if: controller request/response plus serial rx/tx byte links.
interface uart_word_io_if;
  import uart_word_io_pkg::*;
  logic uart_go;
  logic rors;
  logic [BYTE_W*WORD_BYTES-1:0] wdata;
  logic [BYTE_W*WORD_BYTES-1:0] rdata;
  logic uart_done;
  logic rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic tx_start;
  logic [BYTE_W-1:0] tx_data;
  logic tx_busy;
  logic rx_overflow;
  modport master(
    output uart_go, rors, wdata, rx_valid, rx_data, tx_busy,
    input rdata, uart_done, tx_start, tx_data, rx_overflow
  );
  modport slave(
    input uart_go, rors, wdata, rx_valid, rx_data, tx_busy,
    output rdata, uart_done, tx_start, tx_data, rx_overflow
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead FIFO; push ignored when full, pop ignored when empty.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_word_io.sv
// uart_word_io: moves 32-bit words to/from byte-wide serial FIFOs, little-endian.
// Optional UART_OVERFLOW_FLAG_EN adds a sticky flag for dropped rx bytes.
module uart_word_io
  import uart_word_io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst,
  uart_word_io_if.slave bus
);
  localparam int WW = BYTE_W * WORD_BYTES;
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [WW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic tx_start_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic [BYTE_W-1:0] rx_dout, tx_dout, tx_din;
  logic rx_pop, tx_push, tx_pop;
  assign rx_pop = state_q == RECV && !rx_empty;
  assign tx_push = state_q == SEND && !tx_full;
  // one idle cycle after each start gives the transmitter time to raise tx_busy
  assign tx_pop = !tx_empty && !bus.tx_busy && !tx_start_q;
  assign tx_din = wdata_q[{cnt_q, 3'b000} +: BYTE_W];
  uart_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_rx (
    .clk(clk), .rst(rst), .push(bus.rx_valid), .din(bus.rx_data),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  uart_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .din(tx_din),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && bus.uart_go) begin
      state_d = bus.rors ? SEND : RECV;
      cnt_d = '0;
      wdata_d = bus.wdata;
    end
    if (rx_pop) rdata_d[{cnt_q, 3'b000} +: BYTE_W] = rx_dout;
    if (rx_pop || tx_push) begin
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'(WORD_BYTES - 1) ? DONE : state_q;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tx_start_q <= tx_pop;
      tx_data_q <= tx_pop ? tx_dout : tx_data_q;
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.uart_done = state_q == DONE;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data = tx_data_q;
`ifdef UART_OVERFLOW_FLAG_EN
  logic ovf_q;
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (bus.rx_valid && rx_full) ovf_q <= 1'b1;
  assign bus.rx_overflow = ovf_q;
`else
  assign bus.rx_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_io.sv
// tb_uart_word_io: scoreboard bench for word receive/send, stalls, overflow and reset abort.
module tb_uart_word_io;
  import uart_word_io_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  uart_word_io_if bus();
  uart_word_io #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, start_cnt = 0;
  logic [7:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [7:0] exp_b;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.uart_done) done_cnt++;
    if (bus.tx_start) begin
      start_cnt++;
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte: got %h, expected no transmission", bus.tx_data);
      end else begin
        exp_b = tx_q.pop_front();
        if (bus.tx_data !== exp_b) begin
          errors++;
          $display("FAIL tx_byte: got %h, expected %h", bus.tx_data, exp_b);
        end
      end
    end
  end

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task push_rx(input logic [7:0] b);
    bus.rx_valid = 1;
    bus.rx_data = b;
    tick(1);
    bus.rx_valid = 0;
  endtask

  task start(input logic r, input logic [31:0] w, output int n);
    n = cyc;
    bus.uart_go = 1;
    bus.rors = r;
    bus.wdata = w;
    if (r) for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    tick(1);
    bus.uart_go = 0;
  endtask

  task wait_done(input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if (bus.uart_done) at = cyc;
    end
    tick(1);
  endtask

  task wait_tx(input int max);
    for (int i = 0; i < max && tx_q.size() > 0; i++) tick(1);
    tick(4);
  endtask

  task recv_word(input logic [31:0] w, input string nm);
    int n, at;
    logic [31:0] e;
    rx_q.push_back(w);
    start(0, '0, n);
    wait_done(20, at);
    e = rx_q.pop_front();
    checks++;
    if (at !== n + 5) begin
      errors++;
      $display("FAIL %s_latency: done at %0d, expected %0d", nm, at, n + 5);
    end
    checks++;
    if (bus.rdata !== e) begin
      errors++;
      $display("FAIL %s_rdata: got %h, expected %h", nm, bus.rdata, e);
    end
  endtask

  task test_reset;
    rst = 1;
    tick(3);
    rst = 0;
    checks++;
    if ({bus.rdata, bus.uart_done, bus.tx_start, bus.tx_data, bus.rx_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h done=%b start=%b tx_data=%h ovf=%b, expected all 0",
               bus.rdata, bus.uart_done, bus.tx_start, bus.tx_data, bus.rx_overflow);
    end
  endtask

  task test_receive;
    logic [31:0] w;
    push_rx(8'h78);
    push_rx(8'h56);
    push_rx(8'h34);
    push_rx(8'h12);
    recv_word(32'h12345678, "recv");
    w = bus.rdata;
    tick(3);
    checks++;
    if (bus.rdata !== w) begin
      errors++;
      $display("FAIL recv_hold: got %h, expected %h", bus.rdata, w);
    end
  endtask

  task test_recv_stall;
    int n, k, at, d0;
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    d0 = done_cnt;
    rx_q.push_back(w);
    start(0, '0, n);
    for (int i = 0; i < 4; i++) begin
      tick(9);
      k = cyc;
      push_rx(w[8*i +: 8]);
    end
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL stall_early_done: %0d pulses, expected 0", done_cnt - d0);
    end
    wait_done(10, at);
    checks++;
    if (at !== k + 2) begin
      errors++;
      $display("FAIL stall_latency: done at %0d, expected %0d", at, k + 2);
    end
    w = rx_q.pop_front();
    checks++;
    if (bus.rdata !== w) begin
      errors++;
      $display("FAIL stall_rdata: got %h, expected %h", bus.rdata, w);
    end
  endtask

  task test_send;
    int n, at, s0;
    bus.tx_busy = 0;
    s0 = start_cnt;
    start(1, 32'hDEADBEEF, n);
    wait_done(20, at);
    checks++;
    if (at !== n + 5) begin
      errors++;
      $display("FAIL send_latency: done at %0d, expected %0d", at, n + 5);
    end
    wait_tx(50);
    checks++;
    if (start_cnt - s0 !== 4) begin
      errors++;
      $display("FAIL send_count: %0d starts, expected 4", start_cnt - s0);
    end
  endtask

  task test_back_to_back;
    int n, at, s0, d0;
    bus.tx_busy = 1;
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      start(1, $urandom(), n);
      wait_done(10, at);
      checks++;
      if (at !== n + 5) begin
        errors++;
        $display("FAIL b2b_latency_%0d: done at %0d, expected %0d", i, at, n + 5);
      end
    end
    d0 = done_cnt;
    start(1, $urandom(), n);
    tick(30);
    checks++;
    if (done_cnt !== d0 || start_cnt !== s0) begin
      errors++;
      $display("FAIL b2b_stall: %0d done pulses and %0d starts while busy, expected 0 and 0",
               done_cnt - d0, start_cnt - s0);
    end
    bus.tx_busy = 0;
    wait_done(100, at);
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL b2b_release: no done after release, expected one");
    end
    wait_tx(200);
    checks++;
    if (start_cnt - s0 !== 20 || tx_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: %0d starts, %0d pending, expected 20 and 0",
               start_cnt - s0, tx_q.size());
    end
  endtask

  task test_overflow;
    logic exp_ovf;
`ifdef UART_OVERFLOW_FLAG_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif
    rst = 1;
    tick(2);
    rst = 0;
    for (int i = 0; i < 17; i++) push_rx(8'(i));
    tick(1);
    checks++;
    if (bus.rx_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_flag: got %b, expected %b", bus.rx_overflow, exp_ovf);
    end
    for (int w = 0; w < 4; w++)
      recv_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, "ovf");
    push_rx(8'hC0);
    push_rx(8'hC1);
    push_rx(8'hC2);
    push_rx(8'hC3);
    recv_word(32'hC3C2C1C0, "ovf_after");
    checks++;
    if (bus.rx_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, expected %b", bus.rx_overflow, exp_ovf);
    end
  endtask

  task test_reset_mid;
    int n, at, d0, s0;
    bus.tx_busy = 1;
    start(1, 32'h55667788, n);
    wait_done(10, at);
    push_rx(8'h11);
    push_rx(8'h22);
    push_rx(8'h33);
    d0 = done_cnt;
    s0 = start_cnt;
    start(0, '0, n);
    tick(2);
    rst = 1;
    tx_q.delete();
    tick(2);
    rst = 0;
    checks++;
    if (bus.rdata !== 32'h0 || bus.rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: rdata=%h ovf=%b, expected 0 and 0", bus.rdata, bus.rx_overflow);
    end
    bus.tx_busy = 0;
    tick(20);
    checks++;
    if (done_cnt !== d0 || start_cnt !== s0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d done pulses and %0d starts, expected 0 and 0",
               done_cnt - d0, start_cnt - s0);
    end
    push_rx(8'h11);
    push_rx(8'h22);
    push_rx(8'h33);
    push_rx(8'h44);
    recv_word(32'h44332211, "midrst_next");
  endtask

  initial begin
    bus.uart_go = 0;
    bus.rors = 0;
    bus.wdata = '0;
    bus.rx_valid = 0;
    bus.rx_data = '0;
    bus.tx_busy = 0;
    test_reset;
    test_receive;
    test_recv_stall;
    test_send;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
